// File: rtl/game_uart_reporter.sv
// game_uart_reporter: turns game events (GO, SCORE, END) into ASCII status
// lines and feeds them, one byte at a time, to a shared UART transmitter.
// Events are captured on a registered edge-detect stage, buffered in a small
// FIFO, and each line's score/count_down are frozen when its message starts.
module game_uart_reporter #(
   parameter int SCORE_DIGITS = 4,
   parameter int CD_W         = 8,
   parameter int QDEPTH       = 4
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      enable,
   input  logic                      start,
   input  logic                      over,
   input  logic                      score_inc,
   input  logic [4*SCORE_DIGITS-1:0] score,
   input  logic [CD_W-1:0]           count_down,
   input  logic                      tx_busy,
   output logic                      tx_transmit,
   output logic [7:0]                tx_byte,
   output logic                      busy,
   output logic [7:0]                drop_cnt
);

   localparam int SC_W   = 4 * SCORE_DIGITS;
   localparam int HEX_D  = CD_W / 4;
   localparam int SC_LEN = SCORE_DIGITS + HEX_D + 5;
   localparam int IDX_W  = $clog2(SC_LEN + 1);
   localparam int PW     = $clog2(QDEPTH);

   typedef enum logic [1:0] {EV_GO, EV_SCORE, EV_END} ev_t;
   typedef enum logic [2:0] {IDLE, LOAD, SEND, GAP, WAITB} state_t;

   state_t               state;
   ev_t                  kind;
   logic [IDX_W-1:0]     idx;
   logic [SC_W-1:0]      sc_snap;
   logic [CD_W-1:0]      cd_snap;

   logic                 prev_start;
   logic                 prev_over;
   logic                 ev_go;
   logic                 ev_sc;
   logic                 ev_end;

   ev_t                  q_mem [QDEPTH];
   logic [PW-1:0]        rd_ptr;
   logic [PW-1:0]        wr_ptr;
   logic [PW:0]          q_cnt;
   ev_t                  q_head;

   logic                 pop;
   logic [PW+1:0]        free;
   logic                 ok_go;
   logic                 ok_sc;
   logic                 ok_end;
   logic [1:0]           slot_sc;
   logic [1:0]           slot_end;
   logic [1:0]           n_push;
   logic [1:0]           n_ev;
   logic [1:0]           n_drop;
   logic [8:0]           drop_sum;
   logic [PW-1:0]        wa_sc;
   logic [PW-1:0]        wa_end;

   // ASCII for one nibble: 0-9 -> '0'-'9', 10-15 -> 'A'-'F'
   function automatic logic [7:0] enc_digit(input logic [3:0] d);
      if (d < 4'd10) return 8'h30 + {4'h0, d};
      return 8'h37 + {4'h0, d};
   endfunction

   // Index of the final byte (LF) of each message type
   function automatic logic [IDX_W-1:0] last_idx(input ev_t k);
      case (k)
         EV_GO:    return IDX_W'(3);
         EV_SCORE: return IDX_W'(SC_LEN - 1);
         default:  return IDX_W'(4);
      endcase
   endfunction

   // Byte at position i of a message; digits are sent MSD first
   function automatic logic [7:0] msg_byte(input ev_t k, input logic [IDX_W-1:0] i_idx,
                                           input logic [SC_W-1:0] sc, input logic [CD_W-1:0] cd);
      int i;
      i = int'(i_idx);
      msg_byte = 8'h0A;
      case (k)
         EV_GO: begin
            case (i)
               0:       msg_byte = 8'h47;
               1:       msg_byte = 8'h4F;
               2:       msg_byte = 8'h0D;
               default: msg_byte = 8'h0A;
            endcase
         end
         EV_END: begin
            case (i)
               0:       msg_byte = 8'h45;
               1:       msg_byte = 8'h4E;
               2:       msg_byte = 8'h44;
               3:       msg_byte = 8'h0D;
               default: msg_byte = 8'h0A;
            endcase
         end
         default: begin
            if (i == 0)
               msg_byte = 8'h53;
            else if (i <= SCORE_DIGITS)
               msg_byte = enc_digit(4'(sc >> (4 * (SCORE_DIGITS - i))));
            else if (i == SCORE_DIGITS + 1)
               msg_byte = 8'h20;
            else if (i == SCORE_DIGITS + 2)
               msg_byte = 8'h54;
            else if (i <= SCORE_DIGITS + 2 + HEX_D)
               msg_byte = enc_digit(4'(cd >> (4 * (SCORE_DIGITS + 2 + HEX_D - i))));
            else if (i == SCORE_DIGITS + 3 + HEX_D)
               msg_byte = 8'h0D;
            else
               msg_byte = 8'h0A;
         end
      endcase
   endfunction

   // Edge detection and event capture; events are registered before enqueue
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         prev_start <= 1'b0;
         prev_over  <= 1'b0;
         ev_go      <= 1'b0;
         ev_sc      <= 1'b0;
         ev_end     <= 1'b0;
      end else begin
         prev_start <= start;
         prev_over  <= over;
         ev_go      <= enable & start & ~prev_start;
         ev_sc      <= enable & score_inc;
         ev_end     <= enable & over & ~prev_over;
      end
   end

   // Slot allocation: GO, SCORE, END take consecutive free slots in that order,
   // with room counted after this cycle's pop
   always_comb begin
      pop      = (state == LOAD);
      free     = (PW+2)'(QDEPTH) - {1'b0, q_cnt} + {{(PW+1){1'b0}}, pop};
      ok_go    = ev_go && (free != '0);
      slot_sc  = {1'b0, ok_go};
      ok_sc    = ev_sc && (free > (PW+2)'(slot_sc));
      slot_end = slot_sc + {1'b0, ok_sc};
      ok_end   = ev_end && (free > (PW+2)'(slot_end));
      n_push   = slot_end + {1'b0, ok_end};
      n_ev     = {1'b0, ev_go} + {1'b0, ev_sc} + {1'b0, ev_end};
      n_drop   = n_ev - n_push;
      drop_sum = {1'b0, drop_cnt} + {7'h00, n_drop};
      wa_sc    = wr_ptr + PW'(slot_sc);
      wa_end   = wr_ptr + PW'(slot_end);
      q_head   = q_mem[rd_ptr];
   end

   // Queue pointers, occupancy and saturating drop counter
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         q_cnt    <= '0;
         drop_cnt <= 8'h00;
      end else begin
         if (pop) rd_ptr <= rd_ptr + PW'(1);
         wr_ptr   <= wr_ptr + PW'(n_push);
         q_cnt    <= q_cnt - (PW+1)'(pop) + (PW+1)'(n_push);
         drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
      end
   end

   // Queue storage; contents need no reset since occupancy is tracked separately
   always_ff @(posedge clk) begin
      if (ok_go)  q_mem[wr_ptr] <= EV_GO;
      if (ok_sc)  q_mem[wa_sc]  <= EV_SCORE;
      if (ok_end) q_mem[wa_end] <= EV_END;
   end

   // Freeze message type and the values it reports when the message starts
   always_ff @(posedge clk) begin
      if (state == LOAD) begin
         kind    <= q_head;
         sc_snap <= score;
         cd_snap <= count_down;
      end
   end

   // Transmit sequencer: one strobe, one latency cycle, then wait for the UART
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state       <= IDLE;
         idx         <= '0;
         tx_transmit <= 1'b0;
         tx_byte     <= 8'h00;
      end else begin
         case (state)
            IDLE: begin
               tx_transmit <= 1'b0;
               // also wait out a UART still busy from a line abandoned by reset
               if (q_cnt != '0 && !tx_busy) state <= LOAD;
            end
            LOAD: begin
               idx         <= '0;
               tx_transmit <= 1'b1;
               tx_byte     <= msg_byte(q_head, IDX_W'(0), score, count_down);
               state       <= SEND;
            end
            SEND: begin
               tx_transmit <= 1'b0;
               state       <= GAP;
            end
            GAP: begin
               state <= WAITB;
            end
            WAITB: begin
               if (!tx_busy) begin
                  if (idx != last_idx(kind)) begin
                     idx         <= idx + IDX_W'(1);
                     tx_transmit <= 1'b1;
                     tx_byte     <= msg_byte(kind, idx + IDX_W'(1), sc_snap, cd_snap);
                     state       <= SEND;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: begin
               tx_transmit <= 1'b0;
               state       <= IDLE;
            end
         endcase
      end
   end

   assign busy = (q_cnt != '0) || (state != IDLE);

endmodule
